// File: rtl/uart_fifo_param.sv
// Parametrised UART FIFO: first-word fall-through, trigger level, flush, sticky overrun/underrun.
// Define UART_FIFO_ERRBITS_EN to store a 3-bit line-error tag per entry (err_out/err_any live).
module uart_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wb_rst_i,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [2:0]            err_in,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [ADDR_WIDTH:0]   trig_lvl,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [2:0]            err_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  trig,
  output logic                  err_any,
  output logic                  overrun,
  output logic                  underrun
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic                  underrun_q, underrun_d;
  logic                  push_ok, pop_ok, wr_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

  // A full FIFO can still accept a push when the same cycle pops the head.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign wr_en   = push_ok && !flush;

  // Count never exceeds the depth, so an out-of-range trig_lvl simply never fires.
  assign trig = (trig_lvl != '0) && (count_q >= trig_lvl);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (push && !push_ok) overrun_d  = 1'b1;
      if (pop && empty)     underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage is never reset or flushed; the empty gating hides stale words.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= data_in;
  end

  assign data_out = empty ? '0 : mem[rd_ptr_q];

`ifdef UART_FIFO_ERRBITS_EN
  logic [2:0]          tag_mem [DEPTH];
  logic [2:0]          head_tag;
  logic [ADDR_WIDTH:0] err_cnt_q, err_cnt_d;
  logic                err_inc, err_dec;

  assign head_tag = tag_mem[rd_ptr_q];
  assign err_inc  = push_ok && (err_in != 3'd0);
  assign err_dec  = pop_ok && (head_tag != 3'd0);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (flush) begin
      err_cnt_d = '0;
    end else begin
      case ({err_inc, err_dec})
        2'b10:   err_cnt_d = err_cnt_q + 1'b1;
        2'b01:   err_cnt_d = err_cnt_q - 1'b1;
        default: err_cnt_d = err_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) err_cnt_q <= '0;
    else          err_cnt_q <= err_cnt_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) tag_mem[wr_ptr_q] <= err_in;
  end

  assign err_out = empty ? 3'd0 : head_tag;
  assign err_any = (err_cnt_q != '0);
`else
  logic unused_err_in;
  assign unused_err_in = ^err_in;
  assign err_out = 3'd0;
  assign err_any = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_param.sv
// Directed bench for uart_fifo_param: queue-based reference model checked every cycle,
// plus literal expectations from the test plan. Honours UART_FIFO_ERRBITS_EN like the DUT.
module tb_uart_fifo_param;

  localparam int DEPTH = 16;
`ifdef UART_FIFO_ERRBITS_EN
  localparam bit ERRB = 1'b1;
`else
  localparam bit ERRB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic [7:0] data_in;
  logic [2:0] err_in;
  logic       push, pop, flush;
  logic [4:0] trig_lvl;
  logic [7:0] data_out;
  logic [2:0] err_out;
  logic [4:0] count;
  logic       empty, full, trig, err_any, overrun, underrun;

  uart_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .data_in(data_in), .err_in(err_in),
    .push(push), .pop(pop), .flush(flush), .trig_lvl(trig_lvl),
    .data_out(data_out), .err_out(err_out), .count(count), .empty(empty),
    .full(full), .trig(trig), .err_any(err_any), .overrun(overrun), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [2:0] e;
  } entry_t;

  entry_t m_q[$];
  bit     m_ovr, m_unr;
  int     checks = 0;
  int     failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour: pop (if anything stored) happens before push, so a full
  // FIFO with a simultaneous pop has room for the new word.
  task automatic model_step(input bit p, input bit po, input bit f, input logic [7:0] d,
                            input logic [2:0] e);
    bit   pop_v;
    entry_t n;
    if (f) begin
      m_q.delete();
      m_ovr = 0;
      m_unr = 0;
    end else begin
      pop_v = po && (m_q.size() > 0);
      if (po && m_q.size() == 0) m_unr = 1;
      if (pop_v) void'(m_q.pop_front());
      if (p) begin
        if (m_q.size() < DEPTH) begin
          n.d = d;
          n.e = ERRB ? e : 3'd0;
          m_q.push_back(n);
        end else begin
          m_ovr = 1;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!wb_rst_i) begin
      int sz;
      bit any;
      sz  = m_q.size();
      any = 0;
      foreach (m_q[i]) if (m_q[i].e != 3'd0) any = 1;
      chk("count", int'(count), sz);
      chk("empty", int'(empty), int'(sz == 0));
      chk("full", int'(full), int'(sz == DEPTH));
      chk("trig", int'(trig), int'(trig_lvl != 0 && sz >= int'(trig_lvl)));
      chk("data_out", int'(data_out), sz > 0 ? int'(m_q[0].d) : 0);
      chk("err_out", int'(err_out), sz > 0 ? int'(m_q[0].e) : 0);
      chk("err_any", int'(err_any), int'(any));
      chk("overrun", int'(overrun), int'(m_ovr));
      chk("underrun", int'(underrun), int'(m_unr));
    end
  end

  task automatic step(input bit p, input bit po, input bit f, input logic [7:0] d,
                      input logic [2:0] e);
    push = p; pop = po; flush = f; data_in = d; err_in = e;
    @(posedge clk);
    model_step(p, po, f, d, e);
    @(negedge clk);
    #1;
    push = 0; pop = 0; flush = 0;
  endtask

  initial begin
    wb_rst_i = 1; push = 0; pop = 0; flush = 0; data_in = 0; err_in = 0; trig_lvl = 5'd5;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_trig", int'(trig), 0);
    chk("rst_data_out", int'(data_out), 0);
    wb_rst_i = 0;

    // Fill to depth, then overflow
    trig_lvl = 5'd0;
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'h11 + 8'(i), 3'd0);
    chk("lit_full_count", int'(count), 16);
    chk("lit_full", int'(full), 1);
    chk("lit_head_11", int'(data_out), 8'h11);
    chk("lit_no_overrun", int'(overrun), 0);
    step(1, 0, 0, 8'h55, 3'd0);
    chk("lit_overrun", int'(overrun), 1);
    chk("lit_ovr_count", int'(count), 16);
    for (int i = 0; i < 16; i++) begin
      chk("lit_drain", int'(data_out), 8'h11 + i);
      step(0, 1, 0, 8'h00, 3'd0);
    end

    // Full push+pop, then over-drain
    step(0, 0, 1, 8'h00, 3'd0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 8'h40 + 8'(i), 3'd0);
    step(1, 1, 0, 8'hAA, 3'd0);
    chk("lit_pp_count", int'(count), 16);
    chk("lit_pp_overrun", int'(overrun), 0);
    chk("lit_pp_head", int'(data_out), 8'h41);
    for (int i = 0; i < 20; i++) begin
      if (i == 15) chk("lit_last_aa", int'(data_out), 8'hAA);
      step(0, 1, 0, 8'h00, 3'd0);
      if (i == 15) chk("lit_no_unr_yet", int'(underrun), 0);
      if (i == 16) begin
        chk("lit_underrun", int'(underrun), 1);
        chk("lit_unr_data", int'(data_out), 0);
      end
    end

    // Push+pop while empty
    step(0, 0, 1, 8'h00, 3'd0);
    step(1, 1, 0, 8'h3C, 3'd0);
    chk("lit_ep_count", int'(count), 1);
    chk("lit_ep_unr", int'(underrun), 1);
    chk("lit_ep_data", int'(data_out), 8'h3C);

    // Trigger level
    step(0, 0, 1, 8'h00, 3'd0);
    trig_lvl = 5'd4;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h70 + 8'(i), 3'd0);
    chk("lit_trig3", int'(trig), 0);
    step(1, 0, 0, 8'h73, 3'd0);
    chk("lit_trig4", int'(trig), 1);
    step(0, 1, 0, 8'h00, 3'd0);
    chk("lit_trig_pop", int'(trig), 0);
    trig_lvl = 5'd0;
    for (int i = 0; i < 13; i++) step(1, 0, 0, 8'h80 + 8'(i), 3'd0);
    chk("lit_trig0_full", int'(trig), 0);
    trig_lvl = 5'd17; #1;
    chk("lit_trig17", int'(trig), 0);
    trig_lvl = 5'd16; #1;
    chk("lit_trig16", int'(trig), 1);

    // Flush with push, then wrap traffic
    step(0, 0, 1, 8'h00, 3'd0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'h90 + 8'(i), 3'd0);
    step(1, 0, 1, 8'h99, 3'd0);
    chk("lit_fl_count", int'(count), 0);
    chk("lit_fl_empty", int'(empty), 1);
    step(1, 0, 0, 8'h01, 3'd0);
    chk("lit_fl_discard", int'(data_out), 8'h01);
    step(1, 0, 0, 8'h02, 3'd0);
    step(1, 0, 0, 8'h03, 3'd0);
    for (int i = 0; i < 40; i++) begin
      if (i >= 3) chk("lit_wrap", int'(data_out), 8'hC0 + i - 3);
      step(1, 1, 0, 8'hC0 + 8'(i), 3'(i % 8));
    end

    // Error tags
    step(0, 0, 1, 8'h00, 3'd0);
    step(1, 0, 0, 8'h61, 3'd0);
    step(1, 0, 0, 8'h62, 3'd4);
    step(1, 0, 0, 8'h63, 3'd0);
    chk("lit_err_any", int'(err_any), ERRB ? 1 : 0);
    step(0, 1, 0, 8'h00, 3'd0);
    chk("lit_err_out4", int'(err_out), ERRB ? 4 : 0);
    step(0, 1, 0, 8'h00, 3'd0);
    chk("lit_err_clear", int'(err_any), 0);
    chk("lit_err_out0", int'(err_out), 0);

    // Asynchronous reset mid-operation
    step(1, 0, 0, 8'hD1, 3'd1);
    step(1, 0, 0, 8'hD2, 3'd0);
    #2 wb_rst_i = 1;
    #1;
    chk("lit_arst_count", int'(count), 0);
    chk("lit_arst_empty", int'(empty), 1);
    chk("lit_arst_data", int'(data_out), 0);
    chk("lit_arst_err_any", int'(err_any), 0);
    m_q.delete(); m_ovr = 0; m_unr = 0;
    @(posedge clk);
    @(negedge clk); #1;
    wb_rst_i = 0;
    step(1, 0, 0, 8'hE5, 3'd0);
    chk("lit_post_rst", int'(data_out), 8'hE5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
